// File: rtl/mini_pkg.sv
// Shared types for the mini stream tracker.
// FSM encoding and frame counter width.
package mini_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/mini_cmp_stage.sv
// Running extreme tracker with first-occurrence index.
// DIR=0 tracks the minimum, DIR=1 the maximum.
module mini_cmp_stage
  import mini_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int IDX_W = 3,
  parameter bit DIR   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             first,
  input  logic [WIDTH-1:0] data,
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] nxt_val,
  output logic [IDX_W-1:0] nxt_idx
);

  logic [WIDTH-1:0] cur_val;
  logic [IDX_W-1:0] cur_idx;
  logic             better;

  // strict compare keeps the earlier index on ties
  always_comb begin
    better  = DIR ? (data > cur_val)
                  : (data < cur_val);
    nxt_val = cur_val;
    nxt_idx = cur_idx;
    if (first || better) begin
      nxt_val = data;
      nxt_idx = idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_val <= '0;
      cur_idx <= '0;
    end else if (en) begin
      cur_val <= nxt_val;
      cur_idx <= nxt_idx;
    end
  end

endmodule

// File: rtl/mini_stream_tracker.sv
// Framed stream min (and optional max) tracker.
// Optional max tracking: define MINI_MAXTRACK_EN.
module mini_stream_tracker
  import mini_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int FRAME_LEN = 8,
  parameter int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_min,
  output logic [IDX_W-1:0]       out_idx,
`ifdef MINI_MAXTRACK_EN
  output logic [WIDTH-1:0]       out_max,
  output logic [IDX_W-1:0]       out_max_idx,
`endif
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  state_t           state;
  logic [IDX_W-1:0] count;
  logic             accept;
  logic             first;
  logic             last;
  logic [WIDTH-1:0] min_val;
  logic [IDX_W-1:0] min_idx;

  assign accept = in_valid && in_ready;
  assign first  = (count == '0);
  assign last   = (count == IDX_W'(FRAME_LEN - 1));

  mini_cmp_stage #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W),
    .DIR   (1'b0)
  ) u_min (
    .clk     (clk),
    .rst     (rst),
    .en      (accept),
    .first   (first),
    .data    (in_data),
    .idx     (count),
    .nxt_val (min_val),
    .nxt_idx (min_idx)
  );

`ifdef MINI_MAXTRACK_EN
  logic [WIDTH-1:0] max_val;
  logic [IDX_W-1:0] max_idx;

  mini_cmp_stage #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W),
    .DIR   (1'b1)
  ) u_max (
    .clk     (clk),
    .rst     (rst),
    .en      (accept),
    .first   (first),
    .data    (in_data),
    .idx     (count),
    .nxt_val (max_val),
    .nxt_idx (max_idx)
  );
`else
  // min-only build: no max comparator
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_min   <= '0;
      out_idx   <= '0;
`ifdef MINI_MAXTRACK_EN
      out_max     <= '0;
      out_max_idx <= '0;
`endif
      frame_cnt <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          state    <= ACCUM;
          in_ready <= 1'b1;
        end
        (state == ACCUM): begin
          if (accept) begin
            if (last) begin
              // result includes the sample taken this edge
              count     <= '0;
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_min   <= min_val;
              out_idx   <= min_idx;
`ifdef MINI_MAXTRACK_EN
              out_max     <= max_val;
              out_max_idx <= max_idx;
`endif
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        (state == DONE): begin
          if (out_ready) begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 1'b1;
            state     <= ACCUM;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mini_stream_tracker.sv
// Scoreboard bench for mini_stream_tracker.
// Stimulus pushes expectations; a monitor pops on handshake.
module tb_mini_stream_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] out_min;
  logic [2:0] out_idx;
`ifdef MINI_MAXTRACK_EN
  logic [2:0] out_max;
  logic [2:0] out_max_idx;
`endif
  logic [7:0] frame_cnt;

  typedef struct {
    logic [2:0] mn;
    logic [2:0] mi;
    logic [2:0] mx;
    logic [2:0] xi;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_cnt = '0;

  logic [2:0] f1[8] = '{5, 3, 7, 3, 6, 1, 4, 2};
  logic [2:0] f2[8] = '{4, 2, 2, 7, 2, 5, 6, 3};
  logic [2:0] f3[8] = '{0, 5, 4, 3, 2, 1, 6, 7};
  logic [2:0] f4[8] = '{7, 6, 5, 4, 3, 2, 1, 0};

  mini_stream_tracker dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_min     (out_min),
    .out_idx     (out_idx),
`ifdef MINI_MAXTRACK_EN
    .out_max     (out_max),
    .out_max_idx (out_max_idx),
`endif
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] v);
    int n = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready) begin
      if (n++ > 40) begin
        chk("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [2:0] d[8],
                            input logic [2:0] mn,
                            input logic [2:0] mi,
                            input logic [2:0] mx,
                            input logic [2:0] xi,
                            input int gap);
    sb.push_back('{mn, mi, mx, xi, exp_cnt});
    exp_cnt++;
    for (int i = 0; i < 8; i++) begin
      send(d[i]);
      if (i < 7)
        repeat (gap) @(negedge clk);
    end
    #1 chk("latency_out_valid", out_valid, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_min", out_min, e.mn);
          chk("out_idx", out_idx, e.mi);
          chk("frame_cnt", frame_cnt, e.cnt);
`ifdef MINI_MAXTRACK_EN
          chk("out_max", out_max, e.mx);
          chk("out_max_idx", out_max_idx, e.xi);
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_min", out_min, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("idle_in_ready", in_ready, 0);
    @(negedge clk);
    #1 chk("accum_in_ready", in_ready, 1);

    // 1: basic frame
    send_frame(f1, 1, 5, 7, 2, 0);
    @(negedge clk);
    #1 chk("t1_frame_cnt", frame_cnt, 1);

    // 2: ties keep first index
    send_frame(f2, 2, 1, 7, 3, 0);

    // 3: back-pressure
    @(negedge clk);
    out_ready = 1'b0;
    send_frame(f2, 2, 1, 7, 3, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = f3[0];
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_min", out_min, 2);
      chk("bp_out_idx", out_idx, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    send_frame(f3, 0, 0, 7, 7, 0);

    // 4: bubbles
    send_frame(f1, 1, 5, 7, 2, 2);
    @(negedge clk);
    #1 chk("t4_retain_min", out_min, 1);

    // 5: async reset mid-frame
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(f1[i]);
    rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 0);
    chk("ar_out_min", out_min, 0);
    chk("ar_out_idx", out_idx, 0);
    chk("ar_frame_cnt", frame_cnt, 0);
    chk("ar_sb_empty", sb.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    send_frame(f4, 0, 7, 7, 0, 0);
    @(negedge clk);
    #1 chk("t5_frame_cnt", frame_cnt, 1);

    // 6: frame counter wrap
    for (int k = 0; k < 255; k++)
      send_frame(f1, 1, 5, 7, 2, 0);
    @(negedge clk);
    #1 chk("wrap_frame_cnt", frame_cnt, 0);
    send_frame(f1, 1, 5, 7, 2, 0);
    @(negedge clk);
    #1 chk("post_wrap_cnt", frame_cnt, 1);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
